fpu_mul_arb: RTL and testbench

FPU_MUL_ARB -- requirements
Module: fpu_mul_arb

---
 rtl/fpu_mul_arb.sv | 144 ++++++++++++++
 tb/tb_fpu_mul_arb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_arb.sv
// rtl/fpu_mul_arb.sv - two-requester arbiter time-sharing one combinational fp multiplier

// fp_mul: single-precision multiply, round-to-nearest-even, subnormals flushed to zero.
module fp_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic        sign, norm, guard, sticky, round_up;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0] prod;
  logic [22:0] mant;
  logic [23:0] mant_r;
  logic [10:0] e_biased;
  logic [7:0]  e_out;

  always_comb begin
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    norm   = prod[47];
    if (norm) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    round_up = guard && (sticky || mant[0]);
    mant_r   = {1'b0, mant} + {23'd0, round_up};
    // Exponent kept biased twice (ea+eb); subtracting 127 mod 256 yields the field
    e_biased = {3'd0, a[30:23]} + {3'd0, b[30:23]} + {10'd0, norm} + {10'd0, mant_r[23]};
    e_out    = e_biased[7:0] - 8'd127;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      result = 32'h7FC0_0000;
    else if (a_inf || b_inf)
      result = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero || e_biased <= 11'd127)
      result = {sign, 31'd0};
    else if (e_biased >= 11'd382)
      result = {sign, 8'hFF, 23'd0};
    else
      result = {sign, e_out, mant_r[22:0]};
  end
endmodule

module fpu_mul_arb #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_result,
  input  logic        resp_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state, state_nx;
  logic [31:0] op_a, op_b, mul_result;
  logic        op_id, ptr, grant_id, accept;
  logic [3:0]  cnt;

  fp_mul u_fp_mul (.a(op_a), .b(op_b), .result(mul_result));

  // Round-robin pointer only matters when both requesters contend
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = ptr;
    else if (req1_valid)          grant_id = 1'b1;
  end

  assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && !rst && req1_valid && grant_id;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    if (resp_valid && resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a        <= 32'd0;
      op_b        <= 32'd0;
      op_id       <= 1'b0;
      ptr         <= 1'b0;
      cnt         <= 4'd0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= 32'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_a  <= grant_id ? req1_a : req0_a;
          op_b  <= grant_id ? req1_b : req0_b;
          op_id <= grant_id;
          ptr   <= ~grant_id;
          cnt   <= CNT_INIT;
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_valid  <= 1'b1;
            resp_id     <= op_id;
            resp_result <= mul_result;
          end
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_mul_arb.sv
// tb/tb_fpu_mul_arb.sv - randomized self-checking bench for fpu_mul_arb

module tb_fpu_mul_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0v = 1'b0, r1v = 1'b0, r0r, r1r, rv, rid, rrdy = 1'b1, busy;
  logic [31:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0, rres;
  logic        s0v = 1'b0, s1v = 1'b0, s0r, s1r, srv, srid, srrdy = 1'b1, sbusy;
  logic [31:0] s0a = '0, s0b = '0, s1a = '0, s1b = '0, srres;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit timed_out;

  logic [63:0] q0[$], q1[$], gop_q[$];
  int          gnt_q[$], rid_q[$];
  logic [31:0] rres_q[$];

  fpu_mul_arb #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(r0r),
    .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(r1r),
    .resp_valid(rv), .resp_id(rid), .resp_result(rres), .resp_ready(rrdy),
    .busy(busy)
  );

  fpu_mul_arb #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(s0v), .req0_a(s0a), .req0_b(s0b), .req0_ready(s0r),
    .req1_valid(s1v), .req1_a(s1a), .req1_b(s1b), .req1_ready(s1r),
    .resp_valid(srv), .resp_id(srid), .resp_result(srres), .resp_ready(srrdy),
    .busy(sbusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Operands carry 11 significant bits so every product is exact and needs no rounding
  function automatic logic [31:0] rand_op();
    logic [7:0] e = 8'($urandom_range(100, 150));
    logic [9:0] f = 10'($urandom);
    return {1'($urandom), e, f, 13'd0};
  endfunction

  function automatic logic [31:0] model_mul(input logic [63:0] op);
    longint ma, mb, p;
    int e;
    ma = longint'({1'b1, op[54:32]});
    mb = longint'({1'b1, op[22:0]});
    p  = ma * mb;
    e  = int'(op[62:55]) + int'(op[30:23]) - 127;
    if (p >= (longint'(1) << 47)) begin
      p = p / 2;
      e = e + 1;
    end
    return {op[63] ^ op[31], 8'(e), 23'((p >> 23) - (longint'(1) << 23))};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives both request queues with resp_ready high, logging grants and responses
  task automatic run_ops(input int n_resp);
    int got = 0;
    int c   = 0;
    bit g0, g1;
    timed_out = 1'b0;
    gnt_q.delete(); gop_q.delete(); rid_q.delete(); rres_q.delete();
    rrdy = 1'b1;
    while (got < n_resp) begin
      r0v = (q0.size() != 0);
      r1v = (q1.size() != 0);
      if (r0v) {r0a, r0b} = q0[0];
      if (r1v) {r1a, r1b} = q1[0];
      @(negedge clk);
      g0 = r0v && r0r;
      g1 = r1v && r1r;
      if (g0) begin gnt_q.push_back(0); gop_q.push_back(q0[0]); end
      if (g1) begin gnt_q.push_back(1); gop_q.push_back(q1[0]); end
      if (rv) begin rid_q.push_back(int'(rid)); rres_q.push_back(rres); got++; end
      @(posedge clk); #1;
      if (g0) void'(q0.pop_front());
      if (g1) void'(q1.pop_front());
      c++;
      if (c > 300) begin timed_out = 1'b1; break; end
    end
    r0v = 1'b0;
    r1v = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; r0v = 1'b1; r1v = 1'b1; r0a = 32'h3F80_0000; r0b = 32'h3F80_0000;
    @(negedge clk);
    total++; if ({r0r, r1r} !== 2'b00) $display("FAIL reset_ready got=%b want=00", {r0r, r1r}); else passed++;
    @(negedge clk);
    total++; if ({busy, rv, rid} !== 3'b000) $display("FAIL reset_flags busy/rv/rid got=%b want=000", {busy, rv, rid}); else passed++;
    total++; if (rres !== 32'd0) $display("FAIL reset_result got=%h want=0", rres); else passed++;
    total++; if ({sbusy, srv} !== 2'b00) $display("FAIL reset_l1 got=%b want=00", {sbusy, srv}); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; r0v = 1'b0; r1v = 1'b0;
  endtask

  task automatic test_single();
    int t = 0;
    int t_acc, t_resp;
    do_reset();
    r0v = 1'b1; r0a = 32'h3F80_0000; r0b = 32'h3F80_0000; rrdy = 1'b1;
    do @(negedge clk); while (!r0r && ++t < 20);
    t_acc = cyc;
    @(posedge clk); #1;
    r0v = 1'b0;
    t = 0;
    do @(negedge clk); while (!rv && ++t < 20);
    t_resp = cyc;
    total++; if (!rv) $display("FAIL single_timeout rv=%b want=1", rv); else passed++;
    total++; if (t_resp - t_acc !== 3) $display("FAIL single_latency got=%0d want=3", t_resp - t_acc); else passed++;
    total++; if (rid !== 1'b0) $display("FAIL single_id got=%b want=0", rid); else passed++;
    total++; if (rres !== 32'h3F80_0000) $display("FAIL single_result got=%h want=3f800000", rres); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_both_valid();
    do_reset();
    q0.delete(); q1.delete();
    q0.push_back({32'h4000_0000, 32'h4000_0000});
    q1.push_back({32'hC000_0000, 32'h4000_0000});
    run_ops(2);
    total++; if (timed_out || rid_q.size() != 2) $display("FAIL both_count got=%0d want=2", rid_q.size()); else passed++;
    if (rid_q.size() == 2) begin
      total++; if (rid_q[0] != 0 || rres_q[0] !== 32'h4080_0000) $display("FAIL both_first got id=%0d res=%h want id=0 res=40800000", rid_q[0], rres_q[0]); else passed++;
      total++; if (rid_q[1] != 1 || rres_q[1] !== 32'hC080_0000) $display("FAIL both_second got id=%0d res=%h want id=1 res=c0800000", rid_q[1], rres_q[1]); else passed++;
    end
  endtask

  task automatic test_alternate();
    do_reset();
    q0.delete(); q1.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({rand_op(), rand_op()});
      q1.push_back({rand_op(), rand_op()});
    end
    run_ops(6);
    total++; if (timed_out || gnt_q.size() != 6) $display("FAIL alt_count got=%0d want=6", gnt_q.size()); else passed++;
    for (int i = 0; i < gnt_q.size() && i < 6; i++) begin
      total++; if (gnt_q[i] != i % 2) $display("FAIL alt_grant[%0d] got=%0d want=%0d", i, gnt_q[i], i % 2); else passed++;
    end
    for (int i = 0; i < rid_q.size() && i < gop_q.size(); i++) begin
      total++;
      if (rid_q[i] != gnt_q[i] || rres_q[i] !== model_mul(gop_q[i]))
        $display("FAIL alt_resp[%0d] got id=%0d res=%h want id=%0d res=%h", i, rid_q[i], rres_q[i], gnt_q[i], model_mul(gop_q[i]));
      else passed++;
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    q0.delete(); q1.delete();
    n = 12;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) q0.push_back({rand_op(), rand_op()});
      else                           q1.push_back({rand_op(), rand_op()});
    end
    run_ops(n);
    total++; if (timed_out || rid_q.size() != n) $display("FAIL rand_count got=%0d want=%0d", rid_q.size(), n); else passed++;
    for (int i = 0; i < rid_q.size() && i < gop_q.size(); i++) begin
      total++;
      if (rid_q[i] != gnt_q[i] || rres_q[i] !== model_mul(gop_q[i]))
        $display("FAIL rand_resp[%0d] got id=%0d res=%h want id=%0d res=%h", i, rid_q[i], rres_q[i], gnt_q[i], model_mul(gop_q[i]));
      else passed++;
    end
  endtask

  task automatic test_stall();
    int t = 0;
    logic [63:0] op;
    logic [31:0] want;
    do_reset();
    op = {rand_op(), rand_op()};
    want = model_mul(op);
    rrdy = 1'b0; r0v = 1'b1; {r0a, r0b} = op;
    do @(negedge clk); while (!r0r && ++t < 20);
    @(posedge clk); #1;
    r0v = 1'b0;
    t = 0;
    do @(negedge clk); while (!rv && ++t < 20);
    total++; if (!rv) $display("FAIL stall_timeout rv=%b want=1", rv); else passed++;
    @(posedge clk); #1;
    r0v = 1'b1; r1v = 1'b1; {r1a, r1b} = {rand_op(), rand_op()};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (rv !== 1'b1) $display("FAIL stall_valid[%0d] got=%b want=1", i, rv); else passed++;
      total++; if (rid !== 1'b0 || rres !== want) $display("FAIL stall_data[%0d] got id=%b res=%h want id=0 res=%h", i, rid, rres, want); else passed++;
      total++; if ({r0r, r1r, busy} !== 3'b001) $display("FAIL stall_ready_busy[%0d] got=%b want=001", i, {r0r, r1r, busy}); else passed++;
    end
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0; rrdy = 1'b1;
    @(negedge clk);
    total++; if (rv !== 1'b1) $display("FAIL stall_release got=%b want=1", rv); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({busy, rv} !== 2'b00) $display("FAIL stall_idle got=%b want=00", {busy, rv}); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_exec();
    int t = 0;
    bit seen = 1'b0;
    do_reset();
    rrdy = 1'b1; r0v = 1'b1; {r0a, r0b} = {rand_op(), rand_op()};
    do @(negedge clk); while (!r0r && ++t < 20);
    total++; if (!r0r) $display("FAIL abort_accept got=%b want=1", r0r); else passed++;
    @(posedge clk); #1;
    r0v = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if ({busy, rv} !== 2'b00) $display("FAIL abort_idle got=%b want=00", {busy, rv}); else passed++;
    total++; if (rres !== 32'd0) $display("FAIL abort_result got=%h want=0", rres); else passed++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rv) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL abort_no_resp got=1 want=0"); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc_c[$];
    logic [63:0] acc_op[$];
    logic [31:0] res[$];
    logic [63:0] op;
    int c = 0;
    bit g;
    do_reset();
    srrdy = 1'b1; s0v = 1'b1;
    op = {rand_op(), rand_op()};
    while (acc_c.size() < 4 && c < 60) begin
      {s0a, s0b} = op;
      @(negedge clk);
      g = s0r;
      if (g) begin acc_c.push_back(cyc); acc_op.push_back(op); end
      if (srv) res.push_back(srres);
      @(posedge clk); #1;
      if (g) op = {rand_op(), rand_op()};
      c++;
    end
    s0v = 1'b0;
    total++; if (acc_c.size() != 4) $display("FAIL b2b_count got=%0d want=4", acc_c.size()); else passed++;
    for (int i = 1; i < acc_c.size(); i++) begin
      total++; if (acc_c[i] - acc_c[i-1] != 3) $display("FAIL b2b_spacing[%0d] got=%0d want=3", i, acc_c[i] - acc_c[i-1]); else passed++;
    end
    for (int i = 0; i < res.size(); i++) begin
      total++; if (res[i] !== model_mul(acc_op[i])) $display("FAIL b2b_result[%0d] got=%h want=%h", i, res[i], model_mul(acc_op[i])); else passed++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_both_valid();
    test_alternate();
    test_stall();
    test_reset_exec();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
